// File: rtl/decrement_scheduler.sv
// Round-robin scheduler sharing one external W-bit decrementer among NCH countdown channels.
// Optional macro DEC_SCHED_CANCEL_EN adds cancel_valid/cancel_ch to abort an active channel.
module decrement_scheduler #(
    parameter int NCH = 4,
    parameter int W   = 4,
    parameter int CW  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_valid,
    input  logic [CW-1:0]  load_ch,
    input  logic [W-1:0]   load_val,
    output logic           load_ready,
    output logic [W-1:0]   dec_a,
    input  logic [W-1:0]   dec_s,
    input  logic           dec_cout,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] expire,
    output logic           err
`ifdef DEC_SCHED_CANCEL_EN
    ,
    input  logic           cancel_valid,
    input  logic [CW-1:0]  cancel_ch
`endif
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [W-1:0]   cnt_r [NCH];
    logic [NCH-1:0] busy_r;
    logic [NCH-1:0] expire_r;
    logic           err_r;
    logic [CW-1:0]  ptr_r;

    logic           gnt_valid_s;
    logic [CW-1:0]  gnt_ch_s;
    logic [W-1:0]   dec_a_s;
    logic           load_ready_s;
    logic           load_acc_s;
    logic           cancel_hit_s;
    logic [CW-1:0]  cancel_ch_s;

    // Channel index reached by stepping 'step' places past 'base', wrapping at NCH.
    function automatic logic [CW-1:0] rr_index(input logic [CW-1:0] base, input int step);
        int sum;
        sum = (int'(base) + step) % NCH;
        return CW'(sum);
    endfunction

    // Grant search: scanned backwards so the nearest busy channel after ptr wins.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_ch_s    = '0;
        for (int i = NCH; i >= 1; i--) begin
            if (busy_r[rr_index(ptr_r, i)] == ST_ACTIVE) begin
                gnt_valid_s = 1'b1;
                gnt_ch_s    = rr_index(ptr_r, i);
            end else begin
                gnt_valid_s = gnt_valid_s;
            end
        end
    end

    // Shared decrementer operand; held at zero when nothing is granted.
    always_comb begin
        dec_a_s = '0;
        if (gnt_valid_s) begin
            dec_a_s = cnt_r[gnt_ch_s];
        end else begin
            dec_a_s = '0;
        end
    end

    // Load handshake: an active channel is never overwritten.
    always_comb begin
        load_ready_s = 1'b0;
        if (int'(load_ch) < NCH) begin
            load_ready_s = (busy_r[load_ch] == ST_IDLE);
        end else begin
            load_ready_s = 1'b0;
        end
    end

    assign load_acc_s = load_valid & load_ready_s;

`ifdef DEC_SCHED_CANCEL_EN
    // Cancel only matters on an active channel; on an idle one it is a no-op.
    always_comb begin
        cancel_ch_s  = cancel_ch;
        cancel_hit_s = 1'b0;
        if (cancel_valid && (int'(cancel_ch) < NCH)) begin
            cancel_hit_s = (busy_r[cancel_ch] == ST_ACTIVE);
        end else begin
            cancel_hit_s = 1'b0;
        end
    end
`else
    assign cancel_ch_s  = '0;
    assign cancel_hit_s = 1'b0;
`endif

    // Channel state, write-back, expire pulses and sticky borrow error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= '0;
            end
            busy_r   <= '0;
            expire_r <= '0;
            err_r    <= 1'b0;
            ptr_r    <= CW'(NCH - 1);
        end else begin
            expire_r <= '0;
            if (gnt_valid_s) begin
                cnt_r[gnt_ch_s] <= dec_s;
                ptr_r           <= gnt_ch_s;
                if (dec_s == '0) begin
                    busy_r[gnt_ch_s]   <= ST_IDLE;
                    expire_r[gnt_ch_s] <= 1'b1;
                end
                if (!dec_cout) begin
                    err_r <= 1'b1;
                end
            end
            if (load_acc_s) begin
                if (load_val != '0) begin
                    cnt_r[load_ch]  <= load_val;
                    busy_r[load_ch] <= ST_ACTIVE;
                end else begin
                    expire_r[load_ch] <= 1'b1;
                end
            end
            // Cancel is applied last so it overrides a same-cycle write-back and its expire.
            if (cancel_hit_s) begin
                cnt_r[cancel_ch_s]    <= '0;
                busy_r[cancel_ch_s]   <= ST_IDLE;
                expire_r[cancel_ch_s] <= 1'b0;
            end
        end
    end

    assign load_ready = load_ready_s;
    assign dec_a      = dec_a_s;
    assign busy       = busy_r;
    assign expire     = expire_r;
    assign err        = err_r;

endmodule

// File: tb/tb_decrement_scheduler.sv
// Self-checking bench for decrement_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model; honours DEC_SCHED_CANCEL_EN.
module tb_decrement_scheduler;

    localparam int NCH = 4;
    localparam int W   = 4;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           load_valid = 1'b0;
    logic [CW-1:0]  load_ch = '0;
    logic [W-1:0]   load_val = '0;
    logic           load_ready;
    logic [W-1:0]   dec_a;
    logic [W-1:0]   dec_s;
    logic           dec_cout;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] expire;
    logic           err;
    logic           cancel_valid = 1'b0;
    logic [CW-1:0]  cancel_ch = '0;
    logic           force_borrow = 1'b0;

    // Behavioural shared decrementer, with an optional forced borrow.
    assign dec_s    = dec_a - 4'd1;
    assign dec_cout = (dec_a != 4'd0) && !force_borrow;

    decrement_scheduler #(.NCH(NCH), .W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ch(load_ch), .load_val(load_val), .load_ready(load_ready),
        .dec_a(dec_a), .dec_s(dec_s), .dec_cout(dec_cout),
        .busy(busy), .expire(expire), .err(err)
`ifdef DEC_SCHED_CANCEL_EN
        , .cancel_valid(cancel_valid), .cancel_ch(cancel_ch)
`endif
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: per-channel remaining count, active flag, last-served channel.
    int       m_cnt [NCH];
    bit       m_act [NCH];
    int       m_ptr;
    bit [3:0] m_exp;
    bit       m_err;

    logic [3:0] obs_dec_a, obs_busy, obs_expire;
    logic       obs_ready, obs_err;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0;
            m_act[i] = 1'b0;
        end
        m_ptr = NCH - 1;
        m_exp = '0;
        m_err = 1'b0;
    endtask

    function automatic int model_pick();
        for (int j = 1; j <= NCH; j++) begin
            if (m_act[(m_ptr + j) % NCH]) return (m_ptr + j) % NCH;
        end
        return -1;
    endfunction

    // One clock: drive inputs, compare outputs mid-cycle, advance the model at the edge.
    task automatic cycle(input bit lv, input int lc, input int lval, input bit cv, input int cc, input bit fb);
        int       g;
        bit       load_ok, cancel_act;
        bit [3:0] nexp, bv;
        load_valid   = lv;
        load_ch      = 2'(lc);
        load_val     = 4'(lval);
        cancel_valid = cv;
        cancel_ch    = 2'(cc);
        force_borrow = fb;
        @(negedge clk);
        obs_dec_a  = dec_a;
        obs_busy   = busy;
        obs_expire = expire;
        obs_ready  = load_ready;
        obs_err    = err;
        g = model_pick();
        for (int i = 0; i < NCH; i++) bv[i] = m_act[i];
        chk("dec_a", dec_a, (g < 0) ? 0 : m_cnt[g]);
        chk("load_ready", load_ready, !m_act[lc]);
        chk("busy", busy, bv);
        chk("expire", expire, m_exp);
        chk("err", err, m_err);
        @(posedge clk);
        nexp    = '0;
        load_ok = lv && !m_act[lc];
`ifdef DEC_SCHED_CANCEL_EN
        cancel_act = cv && m_act[cc];
`else
        cancel_act = 1'b0;
`endif
        if (g >= 0) begin
            m_cnt[g] = (m_cnt[g] - 1) & 15;
            m_ptr    = g;
            if (fb) m_err = 1'b1;
            if (m_cnt[g] == 0) begin
                m_act[g] = 1'b0;
                nexp[g]  = 1'b1;
            end
        end
        if (load_ok) begin
            if (lval != 0) begin
                m_cnt[lc] = lval;
                m_act[lc] = 1'b1;
            end else begin
                nexp[lc] = 1'b1;
            end
        end
        if (cancel_act) begin
            m_act[cc] = 1'b0;
            m_cnt[cc] = 0;
            nexp[cc]  = 1'b0;
        end
        m_exp = nexp;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        int exp_seen [NCH];
        int first;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 4'h0);
        chk("rst_expire", expire, 4'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_dec_a", dec_a, 4'h0);
        chk("rst_ready", load_ready, 1'b1);
        rst_n = 1'b1;

        // Solo countdown of 3
        cycle(1'b1, 0, 3, 1'b0, 0, 1'b0);
        idle(1); chk("t1_a0", obs_dec_a, 4'd3);
        idle(1); chk("t1_a1", obs_dec_a, 4'd2);
        idle(1); chk("t1_a2", obs_dec_a, 4'd1); chk("t1_early", obs_expire, 4'h0);
        idle(1); chk("t1_exp", obs_expire, 4'b0001); chk("t1_busy", obs_busy, 4'h0);
        idle(1); chk("t1_pulse", obs_expire, 4'h0);

        // Zero load expires immediately without going busy
        cycle(1'b1, 1, 0, 1'b0, 0, 1'b0);
        idle(1); chk("t3_exp", obs_expire, 4'b0010); chk("t3_busy", obs_busy, 4'h0);
        idle(1); chk("t3_pulse", obs_expire, 4'h0);

        // Three channels interleaved; each expires exactly once
        for (int i = 0; i < NCH; i++) exp_seen[i] = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, i, 2, 1'b0, 0, 1'b0);
            for (int c = 0; c < NCH; c++) exp_seen[c] += int'(obs_expire[c]);
        end
        for (int k = 0; k < 10; k++) begin
            idle(1);
            for (int c = 0; c < NCH; c++) exp_seen[c] += int'(obs_expire[c]);
        end
        chk("t2_ch0", exp_seen[0], 1);
        chk("t2_ch1", exp_seen[1], 1);
        chk("t2_ch2", exp_seen[2], 1);

        // Load to busy channel stalls and leaves the count alone
        cycle(1'b1, 2, 5, 1'b0, 0, 1'b0);
        cycle(1'b1, 2, 9, 1'b0, 0, 1'b0);
        chk("t4_ready", obs_ready, 1'b0);
        chk("t4_a", obs_dec_a, 4'd5);
        first = -1;
        for (int k = 2; k <= 12; k++) begin
            idle(1);
            if (first < 0 && obs_expire[2]) first = k;
        end
        chk("t4_lat", first, 6);

`ifdef DEC_SCHED_CANCEL_EN
        // Cancel on the service cycle wins over the write-back
        cycle(1'b1, 0, 4, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 0, 1'b0);
        chk("t6_cancel_a", obs_dec_a, 4'd4);
        idle(1); chk("t6_cancel_busy", obs_busy[0], 1'b0); chk("t6_cancel_exp", obs_expire, 4'h0);
        idle(6);
`endif

        // Forced borrow sets sticky err
        cycle(1'b1, 0, 4, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
        idle(1); chk("t6_err", obs_err, 1'b1);
        idle(8); chk("t6_err_hold", obs_err, 1'b1);

        // Asynchronous reset in the middle of a long count
        cycle(1'b1, 3, 15, 1'b0, 0, 1'b0);
        idle(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 4'h0);
        chk("t5_expire", expire, 4'h0);
        chk("t5_err", err, 1'b0);
        chk("t5_dec_a", dec_a, 4'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        first = 0;
        for (int k = 0; k < 20; k++) begin
            idle(1);
            first += (obs_expire != 4'h0) ? 1 : 0;
        end
        chk("t5_no_exp", first, 0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 49) == 0));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
